// File: rtl/serial_deser_if.sv
// Serial-in / parallel-out bus for serial_deser. The parity_err signal exists only
// when SERIAL_DESER_PARITY_EN is defined.
interface serial_deser_if #(
  parameter int W = 4
);
  logic                       s_in;
  logic                       s_valid;
  logic                       lsb_first;
  logic signed [W-1:0]        p_data;
  logic                       p_valid;
  logic                       p_ready;
  logic [$clog2(W+2)-1:0]     bit_cnt;
  logic                       overrun;
  logic                       clr_ovr;
`ifdef SERIAL_DESER_PARITY_EN
  logic                       parity_err;
`endif

  // The bit source and word consumer drive the stream and the handshake.
  modport master (
    output s_in, s_valid, lsb_first, p_ready, clr_ovr,
`ifdef SERIAL_DESER_PARITY_EN
    input  parity_err,
`endif
    input  p_data, p_valid, bit_cnt, overrun
  );

  // The deserializer consumes bits and presents words.
  modport slave (
    input  s_in, s_valid, lsb_first, p_ready, clr_ovr,
`ifdef SERIAL_DESER_PARITY_EN
    output parity_err,
`endif
    output p_data, p_valid, bit_cnt, overrun
  );
endinterface

// File: rtl/serial_deser.sv
// Serial-to-parallel deserializer: W-bit frames, selectable bit order, holding register
// with valid/ready handshake and sticky overrun. SERIAL_DESER_PARITY_EN adds a trailing even-parity bit.
module serial_deser #(
  parameter int W = 4
) (
  input  logic          clk,
  input  logic          rst,
  serial_deser_if.slave bus
);

`ifdef SERIAL_DESER_PARITY_EN
  localparam int F = W + 1;
`else
  localparam int F = W;
`endif
  localparam int CW = $clog2(W + 2);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_W    = CW'(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(F - 1);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    DONE    = 1'b1
  } state_t;

  state_t          state_r;
  state_t          state_next_s;
  logic [W-1:0]    sr_r;
  logic [W-1:0]    sr_next_s;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_next_s;
  logic            lsb_r;
  logic            lsb_next_s;
  logic            lsb_eff_s;
  logic            frame_done_s;
  logic [W-1:0]    word_s;
  logic [W-1:0]    p_data_r;
  logic            p_valid_r;
  logic            overrun_r;

`ifdef SERIAL_DESER_PARITY_EN
  logic            parity_err_r;

  function automatic logic parity_fail(input logic [W-1:0] data, input logic par);
    return (^data) ^ par;
  endfunction

  // The completing bit is the parity bit, so the word is already fully shifted in.
  assign word_s = sr_r;
  assign bus.parity_err = parity_err_r;
`else
  assign word_s = sr_next_s;
`endif

  // Next-state, shift and bit-count logic for the frame collector.
  always_comb begin
    state_next_s = state_r;
    sr_next_s    = sr_r;
    cnt_next_s   = cnt_r;
    lsb_next_s   = lsb_r;
    frame_done_s = 1'b0;
    lsb_eff_s    = (cnt_r == CNT_ZERO) ? bus.lsb_first : lsb_r;

    if (bus.s_valid) begin
      lsb_next_s = lsb_eff_s;
      if (cnt_r < CNT_W) begin
        if (lsb_eff_s) begin
          sr_next_s = {bus.s_in, sr_r[W-1:1]};
        end else begin
          sr_next_s = {sr_r[W-2:0], bus.s_in};
        end
      end else begin
        sr_next_s = sr_r;
      end
      if (cnt_r == CNT_LAST) begin
        cnt_next_s   = CNT_ZERO;
        frame_done_s = 1'b1;
      end else begin
        cnt_next_s   = cnt_r + CNT_ONE;
        frame_done_s = 1'b0;
      end
    end else begin
      lsb_next_s = lsb_r;
    end

    // DONE marks the cycle the word lands; bits arriving then already belong to the next frame.
    case (state_r)
      COLLECT: state_next_s = frame_done_s ? DONE : COLLECT;
      DONE:    state_next_s = COLLECT;
      default: state_next_s = COLLECT;
    endcase
  end

  // Frame collector state: FSM, shift register, bit counter and latched bit order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= COLLECT;
      sr_r    <= {W{1'b0}};
      cnt_r   <= CNT_ZERO;
      lsb_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      sr_r    <= sr_next_s;
      cnt_r   <= cnt_next_s;
      lsb_r   <= lsb_next_s;
    end
  end

  // Output holding register with valid/ready handshake and sticky overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_data_r     <= {W{1'b0}};
      p_valid_r    <= 1'b0;
      overrun_r    <= 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
      parity_err_r <= 1'b0;
`endif
    end else begin
      if (frame_done_s && (!p_valid_r || bus.p_ready)) begin
        p_data_r     <= word_s;
        p_valid_r    <= 1'b1;
`ifdef SERIAL_DESER_PARITY_EN
        parity_err_r <= parity_fail(word_s, bus.s_in);
`endif
      end else if (p_valid_r && bus.p_ready) begin
        p_valid_r <= 1'b0;
      end else begin
        p_valid_r <= p_valid_r;
      end

      // A new drop wins over a simultaneous clear.
      if (frame_done_s && p_valid_r && !bus.p_ready) begin
        overrun_r <= 1'b1;
      end else if (bus.clr_ovr) begin
        overrun_r <= 1'b0;
      end else begin
        overrun_r <= overrun_r;
      end
    end
  end

  assign bus.p_data  = p_data_r;
  assign bus.p_valid = p_valid_r;
  assign bus.bit_cnt = cnt_r;
  assign bus.overrun = overrun_r;

endmodule

// File: tb/tb_serial_deser.sv
// Directed self-checking bench for serial_deser (W=4); parity cases run when
// SERIAL_DESER_PARITY_EN is defined.
module tb_serial_deser;
  localparam int W = 4;
`ifdef SERIAL_DESER_PARITY_EN
  localparam int F = W + 1;
`else
  localparam int F = W;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [W-1:0] pd;

  serial_deser_if #(.W(W)) bus ();
  serial_deser #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  assign pd = bus.p_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.s_valid = 1'b1;
    bus.s_in    = b;
    tick();
    bus.s_valid = 1'b0;
    bus.s_in    = 1'b0;
  endtask

  // seq[3] goes first; p_ready/clr_ovr are applied only with the frame's final bit.
  task automatic send_frame(input logic [3:0] seq, input logic rdy_last, input logic clr_last);
    for (int i = 3; i > 0; i--) send_bit(seq[i]);
`ifdef SERIAL_DESER_PARITY_EN
    send_bit(seq[0]);
    bus.p_ready = rdy_last;
    bus.clr_ovr = clr_last;
    send_bit(^seq);
`else
    bus.p_ready = rdy_last;
    bus.clr_ovr = clr_last;
    send_bit(seq[0]);
`endif
    bus.p_ready = 1'b0;
    bus.clr_ovr = 1'b0;
  endtask

  task automatic consume();
    bus.p_ready = 1'b1;
    tick();
    bus.p_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] seq;
    int exp_cnt;
    bus.s_in = 1'b0; bus.s_valid = 1'b0; bus.lsb_first = 1'b0;
    bus.p_ready = 1'b0; bus.clr_ovr = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    check("rst_p_data", {28'd0, pd}, 32'h0);
    check("rst_p_valid", {31'd0, bus.p_valid}, 32'h0);
    check("rst_bit_cnt", {29'd0, bus.bit_cnt}, 32'h0);
    check("rst_overrun", {31'd0, bus.overrun}, 32'h0);
`ifdef SERIAL_DESER_PARITY_EN
    check("rst_parity_err", {31'd0, bus.parity_err}, 32'h0);
`endif
    rst = 1'b0;

    // MSB first, back-to-back bits 1,1,0,0 -> 1100
    bus.lsb_first = 1'b0;
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    check("msb_cnt3", {29'd0, bus.bit_cnt}, 32'd3);
    check("msb_not_yet_valid", {31'd0, bus.p_valid}, 32'h0);
    send_bit(1'b0);
`ifdef SERIAL_DESER_PARITY_EN
    check("msb_cnt4_parity", {29'd0, bus.bit_cnt}, 32'd4);
    send_bit(1'b0);
`endif
    check("msb_p_valid", {31'd0, bus.p_valid}, 32'h1);
    check("msb_p_data", {28'd0, pd}, 32'hC);
    check("msb_cnt_wrap", {29'd0, bus.bit_cnt}, 32'd0);
    tick();
    check("hold_p_valid", {31'd0, bus.p_valid}, 32'h1);
    check("hold_p_data", {28'd0, pd}, 32'hC);
    consume();
    check("consume_p_valid", {31'd0, bus.p_valid}, 32'h0);

    // LSB first with idle gaps and a mid-frame lsb_first change -> 0011
    bus.lsb_first = 1'b1;
    seq = 4'b1100;
    for (int i = 0; i < 4; i++) begin
      send_bit(seq[3-i]);
      bus.lsb_first = 1'b0;
      exp_cnt = (i + 1 == F) ? 0 : i + 1;
      check("lsb_cnt_step", {29'd0, bus.bit_cnt}, exp_cnt);
      bus.s_in = 1'b1;
      tick();
      check("lsb_gap_cnt", {29'd0, bus.bit_cnt}, exp_cnt);
      bus.s_in = 1'b0;
    end
`ifdef SERIAL_DESER_PARITY_EN
    send_bit(1'b0);
`endif
    check("lsb_p_data", {28'd0, pd}, 32'h3);
    check("lsb_p_valid", {31'd0, bus.p_valid}, 32'h1);
    check("lsb_cnt_end", {29'd0, bus.bit_cnt}, 32'd0);
    consume();

    // Overrun: 1001 pending, 0110 dropped
    send_frame(4'b1001, 1'b0, 1'b0);
    check("ovr_first_word", {28'd0, pd}, 32'h9);
    check("ovr_not_yet", {31'd0, bus.overrun}, 32'h0);
    send_frame(4'b0110, 1'b0, 1'b0);
    check("ovr_old_kept", {28'd0, pd}, 32'h9);
    check("ovr_valid_kept", {31'd0, bus.p_valid}, 32'h1);
    check("ovr_set", {31'd0, bus.overrun}, 32'h1);
    tick();
    check("ovr_sticky", {31'd0, bus.overrun}, 32'h1);
    bus.clr_ovr = 1'b1;
    tick();
    bus.clr_ovr = 1'b0;
    check("ovr_cleared", {31'd0, bus.overrun}, 32'h0);
    check("ovr_clear_data", {28'd0, pd}, 32'h9);

    // Handshake in the same cycle a frame completes -> new word loads
    send_frame(4'b0110, 1'b1, 1'b0);
    check("same_cyc_valid", {31'd0, bus.p_valid}, 32'h1);
    check("same_cyc_data", {28'd0, pd}, 32'h6);
    check("same_cyc_no_ovr", {31'd0, bus.overrun}, 32'h0);
    tick();
    check("same_cyc_stable", {28'd0, pd}, 32'h6);

    // Clear and new overrun in the same cycle -> overrun stays set
    send_frame(4'b1111, 1'b0, 1'b1);
    check("clr_vs_ovr", {31'd0, bus.overrun}, 32'h1);
    check("clr_vs_ovr_data", {28'd0, pd}, 32'h6);

    // Reset mid-frame wins over s_valid, p_ready and clr_ovr
    send_bit(1'b1); send_bit(1'b1);
    check("partial_cnt", {29'd0, bus.bit_cnt}, 32'd2);
    rst = 1'b1; bus.s_valid = 1'b1; bus.s_in = 1'b1; bus.p_ready = 1'b1; bus.clr_ovr = 1'b1;
    tick();
    rst = 1'b0; bus.s_valid = 1'b0; bus.s_in = 1'b0; bus.p_ready = 1'b0; bus.clr_ovr = 1'b0;
    check("mid_rst_cnt", {29'd0, bus.bit_cnt}, 32'd0);
    check("mid_rst_valid", {31'd0, bus.p_valid}, 32'h0);
    check("mid_rst_ovr", {31'd0, bus.overrun}, 32'h0);
    check("mid_rst_data", {28'd0, pd}, 32'h0);
    send_frame(4'b1010, 1'b0, 1'b0);
    check("post_rst_data", {28'd0, pd}, 32'hA);
    check("post_rst_valid", {31'd0, bus.p_valid}, 32'h1);

`ifdef SERIAL_DESER_PARITY_EN
    consume();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    check("par_ok_data", {28'd0, pd}, 32'hB);
    check("par_ok_err", {31'd0, bus.parity_err}, 32'h0);
    consume();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    check("par_bad_data", {28'd0, pd}, 32'hB);
    check("par_bad_err", {31'd0, bus.parity_err}, 32'h1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_deser.md
SERIAL_DESER -- requirements
Module: serial_deser

Interface
REQ-001 Parameter: W, default 4, width of the parallel output word in bits (W >= 2).
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: s_in  input  1  serial data bit.
REQ-005 Port: s_valid  input  1  s_in is valid this cycle and shall be consumed.
REQ-006 Port: lsb_first  input  1  1 = first received bit is bit 0; 0 = first received bit is bit W-1.
REQ-007 Port: p_data  output  W  assembled parallel word, signed.
REQ-008 Port: p_valid  output  1  p_data holds an unconsumed word.
REQ-009 Port: p_ready  input  1  consumer accepts p_data when p_valid && p_ready.
REQ-010 Port: bit_cnt  output  clog2(W+2)  number of bits of the current frame already received.
REQ-011 Port: overrun  output  1  sticky flag: a completed word was dropped.
REQ-012 Port: clr_ovr  input  1  clears overrun.
REQ-013 Port (only with SERIAL_DESER_PARITY_EN): parity_err  output  1  the word on p_data failed its parity check.

Function
REQ-014 Each cycle with s_valid=1 shall shift s_in into an internal shift register and increment bit_cnt; cycles with s_valid=0 shall hold all frame state.
REQ-015 lsb_first shall be sampled on the cycle the first bit of a frame is accepted (bit_cnt=0) and held for the rest of that frame; mid-frame changes shall have no effect.
REQ-016 The frame length F shall be W bits (W+1 with SERIAL_DESER_PARITY_EN).
REQ-017 When the F-th bit is accepted in cycle N, bit_cnt shall return to 0 in cycle N+1, and the word shall be presented on p_data with p_valid=1 in cycle N+1 (latency 1).
REQ-018 The shift register and output register shall be separate, so a new frame may be collected while the previous word waits for p_ready.
REQ-019 p_data and p_valid shall stay stable while p_valid=1 and p_ready=0.
REQ-020 Handshake p_valid && p_ready with no frame completing in the same cycle: p_valid shall be 0 next cycle.
REQ-021 Frame completing with p_valid=0, or with p_valid && p_ready in the same cycle: the new word shall load and p_valid shall be 1 next cycle.
REQ-022 Frame completing with p_valid=1 and p_ready=0: the new word shall be dropped, the old word retained, and overrun set to 1 next cycle.
REQ-023 overrun shall stay 1 until clr_ovr=1 or rst; if clr_ovr and a new overrun occur in the same cycle, overrun shall be 1.
REQ-024 Operation is a two-state FSM: COLLECT (bit_cnt < F) and DONE (one cycle, output register updated), returning to COLLECT; bits with s_valid=1 in DONE shall be accepted as bit 0 of the next frame.

Reset
REQ-025 With rst=1 at a clock edge, next cycle p_data=0, p_valid=0, bit_cnt=0, overrun=0, parity_err=0, FSM=COLLECT; any partial frame is discarded.
REQ-026 rst shall take priority over s_valid, p_ready, and clr_ovr in the same cycle.

Configuration
REQ-027 With macro SERIAL_DESER_PARITY_EN defined, each frame shall carry one extra trailing even-parity bit, parity_err shall be loaded with the XOR of all W data bits and the parity bit whenever p_data loads, and the parity bit shall never appear in p_data.
REQ-028 Without SERIAL_DESER_PARITY_EN, F=W, the parity_err port shall not exist, and no parity logic shall be synthesized.

Verification
REQ-029 W=4, lsb_first=0, bits 1,1,0,0 on consecutive s_valid cycles -> p_data=4'b1100, p_valid=1 exactly one cycle after the 4th bit.
REQ-030 W=4, lsb_first=1, bits 1,1,0,0 with s_valid idle gaps between bits -> p_data=4'b0011, bit_cnt steps 0,1,2,3,0, and gaps change nothing.
REQ-031 Word 4'b1001 pending with p_ready=0, then second frame 0,1,1,0 completes -> p_data stays 4'b1001, overrun=1; clr_ovr pulse -> overrun=0.
REQ-032 p_ready=1 in the same cycle a second frame completes -> p_valid stays 1 and p_data changes to the new word, overrun=0.
REQ-033 rst asserted after 2 of 4 bits -> bit_cnt=0; next 4 bits 1,0,1,0 (MSB first) -> p_data=4'b1010.
REQ-034 With SERIAL_DESER_PARITY_EN, bits 1,0,1,1 + parity 1 -> p_data=4'b1011, parity_err=0; parity 0 -> parity_err=1.
